bcd_limit_counter: RTL and testbench
====================================

Name: bcd_limit_counter

Overview:
- Consumer end of the mode-select interface.
- Takes the limit word `max_out`, limit enable `max_en` and carry enable `carry_en` produced by the mode/limit selector, and implements the programmable DIGITS-wide BCD up/down counter those settings control.
- Its `cnt_out` is the value fed back to the selector as `cnt_in` and to the display path.

Parameters:
- DIGITS, 6, number of BCD digits; counter width is 4*DIGITS bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous reset, active-high
- count_en  input  1  single-cycle count request (one step per high cycle)
- up  input  1  direction: 1 = increment, 0 = decrement
- carry_en  input  1  1 = full ripple-carry counter; 0 = single-digit mode
- max_en  input  1  1 = wrap at max_in; 0 = wrap at all-nines
- max_in  input  4*DIGITS  BCD limit word, driven from the selector's `max_out`
- digit_sel  input  3  digit counted in single-digit mode (0 = least significant)
- load  input  1  synchronous load request
- load_val  input  4*DIGITS  BCD value to load
- cnt_out  output  4*DIGITS  registered BCD count
- wrap  output  1  registered one-cycle pulse on a full-counter wrap

Behaviour:
- Reset: `cnt_out` = 0 and `wrap` = 0 on the first rising edge with reset high. While reset is high, all other inputs are ignored.
- Priority each cycle: reset > load > count_en.
- Latency: `cnt_out` and `wrap` change on the edge that samples `load`/`count_en`, i.e. visible 1 cycle after the request.
- `wrap` is high for exactly the one cycle following a wrapping step, otherwise 0.
- Effective limit L:
  - `max_en` = 1 and `carry_en` = 1: L = `max_in`, with any `max_in` digit > 9 treated as 9.
  - Otherwise: L = all nines (999999 for DIGITS = 6).
- Load: `cnt_out` <= `load_val`, with each digit > 9 clamped to 9. No range check against L. `wrap` = 0.
- Full mode (`carry_en` = 1), `up` = 1:
  - If `cnt_out` >= L (unsigned compare of BCD words), next = 0 and `wrap` pulses. This includes a count left above a newly lowered limit.
  - Else next = `cnt_out` + 1 in BCD: digit i increments when all lower digits are 9; those lower digits go to 0.
- Full mode, `up` = 0:
  - If `cnt_out` = 0, next = L and `wrap` pulses.
  - Else if `cnt_out` > L, next = L, no wrap.
  - Else BCD decrement: digit i decrements when all lower digits are 0; those lower digits go to 9.
- Digit mode (`carry_en` = 0):
  - Only digit `digit_sel` changes; up 9->0, down 0->9. Other digits hold.
  - No carry or borrow propagates, the limit is ignored, `wrap` stays 0.
  - If `digit_sel` >= DIGITS, the request is ignored and the count holds.
- Mode inputs (`carry_en`, `max_en`, `max_in`) may change on any cycle and take effect on the next count step. No state is kept about them.
- `count_en` held high counts once per clock.
- `count_en` and `load` together: load wins and the step is dropped.
- Reset mid-stream: a pending step or `wrap` pulse is discarded and the counter returns to 0.
- Combinational paths from inputs to outputs: none.

Test Plan:
- Reset high 2 cycles with `count_en` = 1 -> `cnt_out` = 000000 and `wrap` = 0 throughout; first step after release gives 000001.
- Full mode, `max_en` = 0: load 009999, one up step -> 010000. Load 999999, up -> 000000 with a one-cycle `wrap` pulse. Then down -> 999999 with a `wrap` pulse.
- `max_en` = 1, `max_in` = 004300: load 004298, three up steps -> 004299, 004300, 000000, `wrap` on the third only. One down step from 000000 -> 004300 with `wrap`.
- Limit lowered below the count: load 123456, then `max_in` = 004300:
  - an up step -> 000000 with `wrap`;
  - after reloading 123456, a down step -> 004300 with no `wrap`.
- Digit mode, `digit_sel` = 2: from 000900, up -> 000000 with no carry into digit 3 and `wrap` = 0; down -> 000900. With `digit_sel` = 7 the count holds.
- Same-cycle `load` = 1 (`load_val` = 0A00F2) and `count_en` = 1 -> `cnt_out` = 090092 (digits clamped) and the step is ignored.

Source files
------------

// File: rtl/bcd_limit_counter.sv
// Programmable DIGITS-wide BCD up/down counter with limit wrap, single-digit mode and load.
// Latency: cnt_out/wrap update on the edge that samples load/count_en (1 cycle after the request).
// Backpressure: none; every count_en cycle is accepted, load overrides a same-cycle step.
module bcd_limit_counter #(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  count_en,
  input  logic                  up,
  input  logic                  carry_en,
  input  logic                  max_en,
  input  logic [4*DIGITS-1:0]   max_in,
  input  logic [2:0]            digit_sel,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt_out,
  output logic                  wrap
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] NINES = {DIGITS{4'h9}};

  // Force any non-decimal nibble down to 9 so downstream arithmetic only sees valid BCD.
  function automatic logic [W-1:0] clamp9(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple BCD increment: a digit steps only while every lower digit rolled 9->0.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple BCD decrement: a digit steps only while every lower digit rolled 0->9.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] lim;
  logic [W-1:0] nxt_cnt;
  logic         nxt_wrap;

  // Effective wrap limit: programmed word only in full mode with the limit enabled.
  always_comb begin
    lim = NINES;
    if (max_en && carry_en) lim = clamp9(max_in);
  end

  // Next-count selection: load beats a step; full mode wraps at lim, digit mode rolls one digit.
  always_comb begin
    nxt_cnt  = cnt_out;
    nxt_wrap = 1'b0;
    if (load) begin
      nxt_cnt = clamp9(load_val);
    end else if (count_en) begin
      if (carry_en) begin
        if (up) begin
          // >= also catches a count stranded above a newly lowered limit.
          if (cnt_out >= lim) begin
            nxt_cnt  = '0;
            nxt_wrap = 1'b1;
          end else begin
            nxt_cnt = bcd_inc(cnt_out);
          end
        end else begin
          if (cnt_out == '0) begin
            nxt_cnt  = lim;
            nxt_wrap = 1'b1;
          end else if (cnt_out > lim) begin
            nxt_cnt = lim;
          end else begin
            nxt_cnt = bcd_dec(cnt_out);
          end
        end
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          if (int'(digit_sel) == i) begin
            if (up) begin
              nxt_cnt[4*i +: 4] = (cnt_out[4*i +: 4] == 4'd9) ? 4'd0 : cnt_out[4*i +: 4] + 4'd1;
            end else begin
              nxt_cnt[4*i +: 4] = (cnt_out[4*i +: 4] == 4'd0) ? 4'd9 : cnt_out[4*i +: 4] - 4'd1;
            end
          end
        end
      end
    end
  end

  // Count and wrap-pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_out <= '0;
      wrap    <= 1'b0;
    end else begin
      cnt_out <= nxt_cnt;
      wrap    <= nxt_wrap;
    end
  end

endmodule

// File: tb/tb_bcd_limit_counter.sv
// Directed self-checking bench for bcd_limit_counter (DIGITS = 6).
// Latency: each step/load is checked 1 cycle after it is presented.
// Backpressure: none; inputs are driven #1 after the rising edge.
module tb_bcd_limit_counter;

  logic        clk;
  logic        reset;
  logic        count_en;
  logic        up;
  logic        carry_en;
  logic        max_en;
  logic [23:0] max_in;
  logic [2:0]  digit_sel;
  logic        load;
  logic [23:0] load_val;
  logic [23:0] cnt_out;
  logic        wrap;

  int n_checks = 0;
  int n_errors = 0;

  bcd_limit_counter #(.DIGITS(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .count_en  (count_en),
    .up        (up),
    .carry_en  (carry_en),
    .max_en    (max_en),
    .max_in    (max_in),
    .digit_sel (digit_sel),
    .load      (load),
    .load_val  (load_val),
    .cnt_out   (cnt_out),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] v, input logic [23:0] exp, input string tag);
    load     = 1'b1;
    load_val = v;
    tick();
    load     = 1'b0;
    check({tag, "_cnt"}, cnt_out, exp);
    check({tag, "_wrap"}, {23'd0, wrap}, 24'd0);
  endtask

  task automatic do_step(input logic dir, input logic [23:0] exp_cnt, input logic exp_wrap,
                         input string tag);
    count_en = 1'b1;
    up       = dir;
    tick();
    count_en = 1'b0;
    check({tag, "_cnt"}, cnt_out, exp_cnt);
    check({tag, "_wrap"}, {23'd0, wrap}, {23'd0, exp_wrap});
  endtask

  initial begin
    reset     = 1'b1;
    count_en  = 1'b1;
    up        = 1'b1;
    carry_en  = 1'b1;
    max_en    = 1'b0;
    max_in    = 24'h000000;
    digit_sel = 3'd0;
    load      = 1'b0;
    load_val  = 24'h000000;

    // Reset held with count_en high: count must stay at zero.
    tick();
    check("rst1_cnt", cnt_out, 24'h000000);
    check("rst1_wrap", {23'd0, wrap}, 24'd0);
    tick();
    check("rst2_cnt", cnt_out, 24'h000000);
    check("rst2_wrap", {23'd0, wrap}, 24'd0);
    reset = 1'b0;
    tick();
    count_en = 1'b0;
    check("first_step", cnt_out, 24'h000001);
    check("first_wrap", {23'd0, wrap}, 24'd0);

    // Full mode, all-nines limit.
    do_load(24'h009999, 24'h009999, "ld9999");
    do_step(1'b1, 24'h010000, 1'b0, "carry4");
    do_load(24'h999999, 24'h999999, "ld999999");
    do_step(1'b1, 24'h000000, 1'b1, "wrap_up");
    tick();
    check("wrap_one_cycle", {23'd0, wrap}, 24'd0);
    do_step(1'b0, 24'h999999, 1'b1, "wrap_dn");

    // Programmed limit 004300.
    max_en = 1'b1;
    max_in = 24'h004300;
    do_load(24'h004298, 24'h004298, "ld4298");
    do_step(1'b1, 24'h004299, 1'b0, "lim_s1");
    do_step(1'b1, 24'h004300, 1'b0, "lim_s2");
    do_step(1'b1, 24'h000000, 1'b1, "lim_s3");
    do_step(1'b0, 24'h004300, 1'b1, "lim_dn0");

    // Count left above the limit.
    do_load(24'h123456, 24'h123456, "ld123456a");
    do_step(1'b1, 24'h000000, 1'b1, "above_up");
    do_load(24'h123456, 24'h123456, "ld123456b");
    do_step(1'b0, 24'h004300, 1'b0, "above_dn");

    // Non-decimal limit digits read as 9: limit 0000F5 -> 000095.
    max_in = 24'h0000F5;
    do_load(24'h000095, 24'h000095, "ld95");
    do_step(1'b1, 24'h000000, 1'b1, "limclamp");

    // Digit mode ignores the limit and never carries.
    carry_en  = 1'b0;
    digit_sel = 3'd2;
    do_load(24'h000900, 24'h000900, "ld900");
    do_step(1'b1, 24'h000000, 1'b0, "dig_up");
    do_step(1'b0, 24'h000900, 1'b0, "dig_dn");
    digit_sel = 3'd7;
    do_step(1'b1, 24'h000900, 1'b0, "dig_sel7");
    digit_sel = 3'd6;
    do_step(1'b0, 24'h000900, 1'b0, "dig_sel6");
    digit_sel = 3'd0;
    do_load(24'h000009, 24'h000009, "ld9");
    do_step(1'b1, 24'h000000, 1'b0, "dig0_up");

    // Load beats a same-cycle step and clamps digits.
    carry_en = 1'b1;
    max_en   = 1'b0;
    count_en = 1'b1;
    up       = 1'b1;
    load     = 1'b1;
    load_val = 24'h0A00F2;
    tick();
    load     = 1'b0;
    count_en = 1'b0;
    check("ld_vs_step", cnt_out, 24'h090092);
    check("ld_vs_step_wrap", {23'd0, wrap}, 24'd0);

    // Reset discards a wrapping step.
    do_load(24'h999999, 24'h999999, "ld_rst");
    reset    = 1'b1;
    count_en = 1'b1;
    tick();
    reset    = 1'b0;
    count_en = 1'b0;
    check("rst_mid_cnt", cnt_out, 24'h000000);
    check("rst_mid_wrap", {23'd0, wrap}, 24'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
